// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed common-anode seven-segment driver showing a paged hex value.
// Define SEG_LZB_EN to blank leading-zero digits (nibble 0 is always shown).
module seg_scan_display #(
  parameter  int DATA_W   = 32,
  parameter  int DIGITS   = 4,
  parameter  int SCAN_DIV = 50000,
  parameter  int PAGE_DIV = 100000000,
  localparam int PAGES    = DATA_W / (4 * DIGITS),
  localparam int PG_W     = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int DG_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              e,
  input  logic              hold,
  input  logic [DATA_W-1:0] x,
  output logic [DIGITS+7:0] DISP,
  output logic [PG_W-1:0]   page
);

  localparam int NIBS = DATA_W / 4;
  localparam int SC_W = $clog2(SCAN_DIV);
  localparam int PC_W = $clog2(PAGE_DIV);

  logic [SC_W-1:0]   scan_cnt;
  logic [PC_W-1:0]   page_cnt;
  logic [DG_W-1:0]   dig_idx;
  logic              pend;
  logic [DATA_W-1:0] snap;

  logic              tick;
  logic              frame;
  logic              page_wrap;
  logic              page_step;
  logic [DG_W-1:0]   dig_next;
  logic [PG_W-1:0]   page_next;

  // Page steps only on the frame edge, using a request that may arrive in that same cycle.
  always_comb begin
    tick      = e && (scan_cnt == SC_W'(SCAN_DIV - 1));
    frame     = tick && (dig_idx == DG_W'(DIGITS - 1));
    page_wrap = e && !hold && (page_cnt == PC_W'(PAGE_DIV - 1));
    page_step = frame && !hold && (pend || page_wrap);
    dig_next  = (dig_idx == DG_W'(DIGITS - 1)) ? '0 : dig_idx + DG_W'(1);
    page_next = (page == PG_W'(PAGES - 1)) ? '0 : page + PG_W'(1);
  end

  logic [3:0]        nibble;
  logic [6:0]        seg;
  logic              dp;
  logic              blank;
  logic [DIGITS-1:0] anode;
  int                nib_pos;
`ifdef SEG_LZB_EN
  logic [NIBS-1:0]   zero_from;
  logic [NIBS-1:0]   zero_sh;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    seg     = 7'b1111111;
    blank   = 1'b0;
    nib_pos = int'(page) * DIGITS + int'(dig_idx);
    nibble  = 4'(snap >> (nib_pos * 4));
    anode   = ~(DIGITS'(1) << dig_idx);
    dp      = (int'(dig_idx) == (int'(page) % DIGITS)) ? 1'b0 : 1'b1;
`ifdef SEG_LZB_EN
    // zero_from[n] is set when nibbles n..NIBS-1 of the snapshot are all zero.
    zero_from[NIBS-1] = (snap[DATA_W-1 -: 4] == 4'h0);
    for (int n = NIBS - 2; n >= 0; n--) begin
      zero_from[n] = zero_from[n+1] && (snap[n*4 +: 4] == 4'h0);
    end
    zero_sh = zero_from >> nib_pos;
    blank   = (nib_pos != 0) && zero_sh[0];
`endif
    case (nibble)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    if (blank) seg = 7'b1111111;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scan_cnt <= '0;
      page_cnt <= '0;
      dig_idx  <= '0;
      page     <= '0;
      pend     <= 1'b0;
      snap     <= '0;
      DISP     <= '1;
    end else if (!e) begin
      // Disabled: position and snapshot are kept so scanning resumes where it stopped.
      scan_cnt <= '0;
      page_cnt <= '0;
      pend     <= 1'b0;
      DISP     <= '1;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + SC_W'(1);
      if (tick)  dig_idx <= dig_next;
      if (frame) snap    <= x;
      if (hold) begin
        page_cnt <= '0;
        pend     <= 1'b0;
      end else begin
        page_cnt <= page_wrap ? '0 : page_cnt + PC_W'(1);
        if (page_step)      pend <= 1'b0;
        else if (page_wrap) pend <= 1'b1;
      end
      if (page_step) page <= page_next;
      DISP <= {anode, seg, dp};
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed bench with a per-cycle behavioural model of the paged hex display.
// Build with SEG_LZB_EN defined to exercise leading-zero blanking.
module tb_seg_scan_display;

  localparam int DATA_W   = 32;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int PAGE_DIV = 40;
  localparam int PAGES    = DATA_W / (4 * DIGITS);
`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        CLK  = 1'b0;
  logic        RST  = 1'b1;
  logic        e    = 1'b1;
  logic        hold = 1'b0;
  logic [31:0] x    = 32'h1234ABCD;
  logic [11:0] DISP;
  logic        page;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  seg_scan_display #(
    .DATA_W(DATA_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .PAGE_DIV(PAGE_DIV)
  ) dut (
    .CLK(CLK), .RST(RST), .e(e), .hold(hold), .x(x), .DISP(DISP), .page(page)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Hex glyphs, a..g active-low, index = nibble value.
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  function automatic logic [11:0] render(input int dig, input int pg, input logic [31:0] s);
    int         n  = pg * DIGITS + dig;
    logic [31:0] up = s >> (4 * n);
    logic [6:0] sg = seg_tab[up[3:0]];
    logic [3:0] an = ~(4'b0001 << dig);
    if (LZB && n > 0 && up == 32'h0) sg = 7'h7F;
    return {an, sg, (dig == pg % DIGITS) ? 1'b0 : 1'b1};
  endfunction

  // Model state: plain integers following the display rules.
  int          m_cnt, m_dig, m_page, m_pcnt;
  bit          m_pend;
  logic [31:0] m_snap;
  logic [11:0] exp_disp;
  int          exp_page;

  task automatic model_step();
    bit frame_now;
    if (RST) begin
      m_cnt = 0; m_dig = 0; m_page = 0; m_pcnt = 0; m_pend = 0;
      m_snap = 0; exp_disp = 12'hFFF;
    end else if (!e) begin
      m_cnt = 0; m_pcnt = 0; m_pend = 0; exp_disp = 12'hFFF;
    end else begin
      exp_disp  = render(m_dig, m_page, m_snap);
      frame_now = (m_cnt == SCAN_DIV - 1) && (m_dig == DIGITS - 1);
      if (hold) begin
        m_pcnt = 0; m_pend = 0;
      end else if (m_pcnt == PAGE_DIV - 1) begin
        m_pcnt = 0; m_pend = 1;
      end else begin
        m_pcnt++;
      end
      if (frame_now) begin
        m_snap = x;
        if (m_pend) begin
          m_page = (m_page + 1) % PAGES;
          m_pend = 0;
        end
      end
      if (m_cnt == SCAN_DIV - 1) begin
        m_cnt = 0;
        m_dig = (m_dig + 1) % DIGITS;
      end else begin
        m_cnt++;
      end
    end
    exp_page = m_page;
  endtask

  initial begin
    exp_disp = 12'hFFF;
    exp_page = 0;
    forever begin
      @(posedge CLK or posedge RST);
      model_step();
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      check("disp_model", {20'h0, DISP}, {20'h0, exp_disp});
      check("page_model", {31'h0, page}, exp_page);
    end
  end

  task automatic goto(input int target);
    while (k < target) begin
      @(negedge CLK);
      k++;
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("reset_disp", {20'h0, DISP}, 32'hFFF);
    check("reset_page", {31'h0, page}, 32'h0);
    RST = 1'b0;
    k   = 0;

    // Before the first frame the snapshot is zero.
    goto(1);   check("pre_d0", {20'h0, DISP}, 32'hE02);
    goto(5);   check("pre_d1", {20'h0, DISP}, LZB ? 32'hDFF : 32'hD03);
    goto(9);   check("pre_d2", {20'h0, DISP}, LZB ? 32'hBFF : 32'hB03);
    goto(13);  check("pre_d3", {20'h0, DISP}, LZB ? 32'h7FF : 32'h703);
    goto(17);  check("p0_d0", {20'h0, DISP}, 32'hE84);
    goto(21);  check("p0_d1", {20'h0, DISP}, 32'hD63);
    goto(25);  check("p0_d2", {20'h0, DISP}, 32'hBC1);
    goto(29);  check("p0_d3", {20'h0, DISP}, 32'h711);

    // Page request at edge 40 waits for the frame at edge 48.
    goto(40);  check("pend_no_step", {31'h0, page}, 32'h0);
    goto(47);  check("pre_frame_pg", {31'h0, page}, 32'h0);
    goto(48);  check("page1", {31'h0, page}, 32'h1);
    goto(49);  check("p1_d0", {20'h0, DISP}, 32'hE99);
    goto(53);  check("p1_d1", {20'h0, DISP}, 32'hD0C);
    goto(57);  check("p1_d2", {20'h0, DISP}, 32'hB25);
    goto(61);  check("p1_d3", {20'h0, DISP}, 32'h79F);
    goto(80);  check("page_wrap", {31'h0, page}, 32'h0);

    // x changes while digit 2 is shown: old snapshot until the next frame.
    goto(89);  x = 32'hFFFF0000;
    goto(93);  check("old_snap_d3", {20'h0, DISP}, 32'h711);
    goto(97);  check("new_snap_d0", {20'h0, DISP}, 32'hE02);

    // Hold for 200 cycles, then 40 cycles plus the wait to the frame at 352.
    goto(100); hold = 1'b1;
    goto(128); check("hold_pg128", {31'h0, page}, 32'h0);
    goto(300); check("hold_pg300", {31'h0, page}, 32'h0);
    hold = 1'b0;
    goto(340); check("rel_pg340", {31'h0, page}, 32'h0);
    goto(351); check("rel_pg351", {31'h0, page}, 32'h0);
    goto(352); check("rel_pg352", {31'h0, page}, 32'h1);
    goto(353); check("ff_p1_d0", {20'h0, DISP}, 32'hE71);

    // Disable mid-frame on digit 1.
    goto(358); e = 1'b0;
    goto(359); check("dis_blank0", {20'h0, DISP}, 32'hFFF);
    goto(368); check("dis_blank9", {20'h0, DISP}, 32'hFFF);
    e = 1'b1;
    goto(369); check("resume_d1", {20'h0, DISP}, 32'hD70);
    goto(372); check("resume_d1b", {20'h0, DISP}, 32'hD70);
    goto(373); check("resume_d2", {20'h0, DISP}, 32'hB71);

    // Asynchronous reset between edges.
    #2 RST = 1'b1;
    #1;
    check("async_disp", {20'h0, DISP}, 32'hFFF);
    check("async_page", {31'h0, page}, 32'h0);
    x = 32'h000000A0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    k   = 0;
    goto(13);  check("rz_d3", {20'h0, DISP}, LZB ? 32'h7FF : 32'h703);
    goto(17);  check("a0_d0", {20'h0, DISP}, 32'hE02);
    goto(21);  check("a0_d1", {20'h0, DISP}, 32'hD11);
    goto(25);  check("a0_d2", {20'h0, DISP}, LZB ? 32'hBFF : 32'hB03);
    goto(29);  check("a0_d3", {20'h0, DISP}, LZB ? 32'h7FF : 32'h703);
    goto(48);  check("a0_page1", {31'h0, page}, 32'h1);
    goto(49);  check("a0_p1_d0", {20'h0, DISP}, LZB ? 32'hEFF : 32'hE03);
    goto(53);  check("a0_p1_d1", {20'h0, DISP}, LZB ? 32'hDFE : 32'hD02);
    goto(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
